// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, centre-sampled, single-byte VLD/ACK holding register with framing and overrun flags
`timescale 1ns/1ps
module uart_rx #(
    parameter int ClkHz = 25_000_000,
    parameter int Baud = 115_200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] OUT,
    output logic       VLD,
    input  logic       ACK,
    output logic       ERR,
    output logic       OVR
);
    localparam int Div = (ClkHz + Baud / 2) / Baud;
    localparam int CW = $clog2(Div);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
    state_t state;
    logic s1, s2;
    logic [CW-1:0] cnt;
    logic [2:0] n;
    logic [7:0] sh;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            OUT <= 8'd0;
            VLD <= 1'b0;
            ERR <= 1'b0;
            OVR <= 1'b0;
            s1 <= 1'b1;
            s2 <= 1'b1;
            cnt <= '0;
            n <= 3'd0;
            sh <= 8'd0;
        end else begin
            s1 <= RX;
            s2 <= s1;
            ERR <= 1'b0;
            OVR <= 1'b0;
            if (VLD && ACK) VLD <= 1'b0;
            // a completion below overrides the ACK clear so a same-cycle ACK hands over the new byte
            case (state)
                IDLE: if (!s2) begin
                    state <= START;
                    cnt <= CW'(Div / 2 - 1);
                end
                START: if (cnt != '0) cnt <= cnt - CW'(1);
                else if (!s2) begin
                    state <= DATA;
                    cnt <= CW'(Div - 1);
                    n <= 3'd0;
                end else state <= IDLE;
                DATA: if (cnt != '0) cnt <= cnt - CW'(1);
                else begin
                    sh <= {s2, sh[7:1]};
                    n <= n + 3'd1;
                    cnt <= CW'(Div - 1);
                    if (n == 3'd7) state <= STOP;
                end
                STOP: if (cnt != '0) cnt <= cnt - CW'(1);
                else if (s2) begin
                    state <= IDLE;
                    if (!VLD || ACK) begin
                        OUT <= sh;
                        VLD <= 1'b1;
                    end else OVR <= 1'b1;
                end else begin
                    ERR <= 1'b1;
                    state <= BRK;
                end
                BRK: if (s2) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 16 CLK per bit
`timescale 1ns/1ps
module tb_uart_rx;
    logic clk = 1'b0, rst, rx, ack;
    logic [7:0] dout;
    logic vld, err, ovr;
    int n_chk = 0, n_fail = 0;
    int err_cnt = 0, ovr_cnt = 0, both_cnt = 0;
    always #5 clk = ~clk;
    uart_rx #(.ClkHz(1_600_000), .Baud(100_000)) dut (
        .CLK(clk), .RST(rst), .RX(rx), .OUT(dout), .VLD(vld), .ACK(ack), .ERR(err), .OVR(ovr)
    );
    always @(negedge clk) begin
        if (err) err_cnt++;
        if (ovr) ovr_cnt++;
        if (err && ovr) both_cnt++;
    end
    typedef struct {
        logic [7:0] data;
        logic stop;
        logic exp_vld;
        logic [7:0] exp_out;
        int exp_err;
    } vec_t;
    vec_t vecs[6];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (16) @(negedge clk);
        end
    endtask
    task automatic idle(input int c);
        rx = 1'b1;
        repeat (c) @(negedge clk);
    endtask
    task automatic ack_pulse();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask
    task automatic wait_vld(output int cyc, input int lim);
        cyc = 0;
        while (!vld && cyc < lim) begin
            @(negedge clk);
            cyc++;
        end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
    initial begin
        int cyc, e0, o0, exp_ovr;
        logic [7:0] held, d;
        bit full;
        vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
        vecs[4] = '{8'h01, 1'b0, 1'b0, 8'h00, 1};
        vecs[5] = '{8'hC3, 1'b0, 1'b0, 8'h00, 1};
        rst = 1'b1; rx = 1'b1; ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_vld", vld, 0);
        chk("reset_out", dout, 0);
        chk("reset_err", err, 0);
        chk("reset_ovr", ovr, 0);
        idle(5);
        // frame 0x55 and start-edge to VLD latency
        fork
            send_frame(8'h55, 1'b1);
            wait_vld(cyc, 400);
        join
        chk("t1_latency_ok", (cyc >= 154 && cyc <= 156), 1);
        chk("t1_out", dout, 8'h55);
        chk("t1_err_ovr", err_cnt + ovr_cnt, 0);
        ack_pulse();
        chk("t1_vld_after_ack", vld, 0);
        chk("t1_out_kept", dout, 8'h55);
        idle(5);
        // back-to-back frames with prompt ACK
        o0 = ovr_cnt;
        fork
            begin
                send_frame(8'hA5, 1'b1);
                send_frame(8'h3C, 1'b1);
            end
            begin
                wait_vld(cyc, 400);
                chk("t2_first_vld", vld, 1);
                chk("t2_first_out", dout, 8'hA5);
                repeat (5) @(negedge clk);
                ack_pulse();
                wait_vld(cyc, 400);
                chk("t2_second_vld", vld, 1);
                chk("t2_second_out", dout, 8'h3C);
                repeat (5) @(negedge clk);
                ack_pulse();
            end
        join
        chk("t2_no_ovr", ovr_cnt - o0, 0);
        chk("t2_vld_clear", vld, 0);
        idle(5);
        // overrun, then ACK on the exact completion cycle
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(4);
        chk("t3_ovr_once", ovr_cnt - o0, 1);
        chk("t3_out_kept", dout, 8'h11);
        chk("t3_vld_held", vld, 1);
        o0 = ovr_cnt;
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (154) @(negedge clk);
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
                chk("t3_ack_same_vld", vld, 1);
                chk("t3_ack_same_out", dout, 8'h22);
            end
        join
        chk("t3_ack_same_no_ovr", ovr_cnt - o0, 0);
        ack_pulse();
        idle(5);
        // framing error with long break, then recovery
        e0 = err_cnt;
        send_frame(8'hFF, 1'b0);
        rx = 1'b0;
        repeat (640) @(negedge clk);
        idle(32);
        chk("t4_err_once", err_cnt - e0, 1);
        chk("t4_vld_low", vld, 0);
        send_frame(8'h42, 1'b1);
        idle(4);
        chk("t4_recover_vld", vld, 1);
        chk("t4_recover_out", dout, 8'h42);
        ack_pulse();
        idle(5);
        // short glitch and reset mid-frame
        e0 = err_cnt; o0 = ovr_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(40);
        chk("t5_glitch_vld", vld, 0);
        chk("t5_glitch_err", err_cnt - e0, 0);
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (130) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        idle(40);
        chk("t5_rst_vld", vld, 0);
        chk("t5_rst_out", dout, 0);
        chk("t5_rst_flags", (err_cnt - e0) + (ovr_cnt - o0), 0);
        send_frame(8'h7E, 1'b1);
        idle(4);
        chk("t5_next_vld", vld, 1);
        chk("t5_next_out", dout, 8'h7E);
        ack_pulse();
        idle(5);
        // table-driven vectors
        foreach (vecs[i]) begin
            e0 = err_cnt;
            send_frame(vecs[i].data, vecs[i].stop);
            idle(8);
            chk($sformatf("vec%0d_vld", i), vld, vecs[i].exp_vld);
            if (vecs[i].exp_vld) chk($sformatf("vec%0d_out", i), dout, vecs[i].exp_out);
            chk($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].exp_err);
            ack_pulse();
            idle(4);
        end
        // random frames against a holding-register model with random ACKs
        full = 0; held = 8'h00; exp_ovr = 0; o0 = ovr_cnt;
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1);
            idle(4);
            if (!full) begin
                held = d;
                full = 1;
            end else exp_ovr++;
            chk($sformatf("rnd%0d_vld", i), vld, full);
            if (full) chk($sformatf("rnd%0d_out", i), dout, held);
            if ($urandom_range(0, 2) != 0) begin
                ack_pulse();
                full = 0;
            end
            idle($urandom_range(0, 20));
        end
        chk("rnd_ovr_count", ovr_cnt - o0, exp_ovr);
        chk("err_ovr_never_together", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
